// File: rtl/tcp_tx_arbiter.sv
// Arbitrates the shared TCP/IP frame writer between control and data segment requests.
// Optional frame statistics counters are built when TCP_TX_ARB_STATS_EN is defined.
module tcp_tx_arbiter #(
  parameter int unsigned IFG_CYC      = 12,
  parameter int unsigned TIMEOUT_CYC  = 65535,
  parameter int unsigned MAX_CTRL_RUN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_req_i,
  input  logic        data_req_i,
  input  logic        tx_done_i,
  output logic        ctrl_start_o,
  output logic        data_start_o,
  output logic        sel_data_o,
  output logic        busy_o,
  output logic        ctrl_pend_o,
  output logic        data_pend_o,
  output logic        timeout_o,
  output logic [15:0] ctrl_cnt_o,
  output logic [15:0] data_cnt_o
);

  localparam int unsigned WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned GAP_W   = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;
  localparam int unsigned RUN_W   = (MAX_CTRL_RUN > 0) ? $clog2(MAX_CTRL_RUN + 1) : 1;
  localparam int unsigned WD_LAST  = (TIMEOUT_CYC > 1) ? (TIMEOUT_CYC - 2) : 0;
  localparam int unsigned GAP_LAST = (IFG_CYC > 0) ? (IFG_CYC - 1) : 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             ctrl_pend_q, ctrl_pend_d;
  logic             data_pend_q, data_pend_d;
  logic             ctrl_start_q, ctrl_start_d;
  logic             data_start_q, data_start_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             ctrl_eff_c, data_eff_c, pick_data_c;

  assign ctrl_eff_c  = ctrl_pend_q | ctrl_req_i;
  assign data_eff_c  = data_pend_q | data_req_i;
  // Data wins only when control is idle or has used up its run budget.
  assign pick_data_c = data_eff_c & (~ctrl_eff_c | (run_q == RUN_W'(MAX_CTRL_RUN)));

  always_comb begin
    state_d      = state_q;
    ctrl_pend_d  = ctrl_pend_q | ctrl_req_i;
    data_pend_d  = data_pend_q | data_req_i;
    ctrl_start_d = 1'b0;
    data_start_d = 1'b0;
    sel_d        = sel_q;
    timeout_d    = 1'b0;
    wd_d         = wd_q;
    gap_d        = gap_q;
    run_d        = run_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl_eff_c | data_eff_c) begin
          state_d = S_GRANT;
          sel_d   = pick_data_c;
          if (pick_data_c) begin
            data_start_d = 1'b1;
            data_pend_d  = 1'b0;
            run_d        = '0;
          end else begin
            ctrl_start_d = 1'b1;
            ctrl_pend_d  = 1'b0;
            if (!data_eff_c) begin
              run_d = '0;
            end else if (run_q != RUN_W'(MAX_CTRL_RUN)) begin
              run_d = run_q + RUN_W'(1);
            end
          end
        end
      end
      S_GRANT: begin
        state_d = S_BUSY;
        wd_d    = '0;
      end
      S_BUSY: begin
        if (tx_done_i) begin
          wd_d    = '0;
          gap_d   = '0;
          state_d = (IFG_CYC == 0) ? S_IDLE : S_GAP;
        end else if (32'(wd_q) >= WD_LAST) begin
          wd_d      = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: begin
        if (32'(gap_q) >= GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ctrl_pend_q  <= 1'b0;
      data_pend_q  <= 1'b0;
      ctrl_start_q <= 1'b0;
      data_start_q <= 1'b0;
      sel_q        <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      wd_q         <= '0;
      gap_q        <= '0;
      run_q        <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_pend_q  <= ctrl_pend_d;
      data_pend_q  <= data_pend_d;
      ctrl_start_q <= ctrl_start_d;
      data_start_q <= data_start_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      wd_q         <= wd_d;
      gap_q        <= gap_d;
      run_q        <= run_d;
    end
  end

  assign ctrl_start_o = ctrl_start_q;
  assign data_start_o = data_start_q;
  assign sel_data_o   = sel_q;
  assign busy_o       = busy_q;
  assign ctrl_pend_o  = ctrl_pend_q;
  assign data_pend_o  = data_pend_q;
  assign timeout_o    = timeout_q;

`ifdef TCP_TX_ARB_STATS_EN
  logic [15:0] ctrl_cnt_q, data_cnt_q;

  // Counts advance on the grant edge, so they already include the frame in its GRANT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_cnt_q <= '0;
      data_cnt_q <= '0;
    end else begin
      if (ctrl_start_d) ctrl_cnt_q <= ctrl_cnt_q + 16'd1;
      if (data_start_d) data_cnt_q <= data_cnt_q + 16'd1;
    end
  end

  assign ctrl_cnt_o = ctrl_cnt_q;
  assign data_cnt_o = data_cnt_q;
`else
  assign ctrl_cnt_o = 16'h0000;
  assign data_cnt_o = 16'h0000;
`endif

endmodule

// File: doc/tcp_tx_arbiter.md
Name: tcp_tx_arbiter

Overview:
Shares the single TCP/IP frame writer between two requesters:
- Control segments: SYN+ACK, FIN and pure ACK, from the connection controller's tcp_start pulse.
- Data segments: from the controller's wdat_start pulse.

It latches requests that arrive while the writer is busy and issues exactly one start pulse per frame. It holds the header-mux select for the whole frame, enforces an inter-frame gap, and recovers from a writer that never reports completion.

Parameters:
- IFG_CYC, 12: idle cycles inserted after each tx_done_i before the next grant (0 = none).
- TIMEOUT_CYC, 65535: BUSY cycles without tx_done_i before abort.
- MAX_CTRL_RUN, 4: consecutive control grants allowed while data is pending before data is forced.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ctrl_req_i  in  1  one-cycle control-segment request.
- data_req_i  in  1  one-cycle data-segment request.
- tx_done_i  in  1  one-cycle pulse from the writer at end of frame.
- ctrl_start_o  out  1  one-cycle start to the writer, control frame.
- data_start_o  out  1  one-cycle start to the writer, data frame.
- sel_data_o  out  1  header-mux select (1 = data fields); stable from start pulse to tx_done_i.
- busy_o  out  1  high in GRANT, BUSY and GAP.
- ctrl_pend_o  out  1  latched control request outstanding.
- data_pend_o  out  1  latched data request outstanding.
- timeout_o  out  1  one-cycle pulse on watchdog abort.
- ctrl_cnt_o  out  16  control frames granted (stats).
- data_cnt_o  out  16  data frames granted (stats).

Behaviour:
- Reset values: all outputs 0, both pend bits 0, all counters 0, state IDLE. Reset is honoured mid-frame; pending requests are lost.
- Effective request per class = pend bit OR that cycle's req input.
- States: IDLE, GRANT, BUSY, GAP.
- IDLE:
  - If any effective request exists: pick a winner, go to GRANT, clear the winner's pend bit, and latch the loser's req into its pend bit.
  - Winner rule: control wins, unless data is effective and run_cnt == MAX_CTRL_RUN; then data wins.
- GRANT (1 cycle):
  - The winner's start output is high (registered).
  - sel_data_o takes the winner's value; it is already valid in this cycle and held until leaving BUSY.
  - Next state is BUSY.
  - Latency: a request in cycle 0 from IDLE gives a start pulse in cycle 1.
- BUSY:
  - Watchdog counter increments every cycle.
  - tx_done_i moves to GAP (or IDLE if IFG_CYC == 0) and clears the watchdog.
  - If the watchdog reaches TIMEOUT_CYC-1 with no done: pulse timeout_o, go to IDLE, keep pend bits.
- GAP: counts IFG_CYC cycles, then goes to IDLE. An effective request in IDLE is granted on the same edge as described above.
- Outside IDLE:
  - Any req_i sets its pend bit.
  - A req while that pend bit is already set merges; no queueing beyond one per class.
  - A req in the same cycle as its own grant is consumed by that grant, not re-latched.
- tx_done_i outside BUSY is ignored.
- run_cnt (width clog2(MAX_CTRL_RUN+1)):
  - Increments on a control grant while data is effective.
  - Clears on a data grant, or on any grant where data is not effective.
  - Saturates at MAX_CTRL_RUN.
- Start outputs are mutually exclusive; at most one start per frame.
- ctrl_cnt_o / data_cnt_o increment on the respective start pulse and wrap 0xFFFF -> 0x0000.

Optional Feature:
- Macro: TCP_TX_ARB_STATS_EN.
- Defined: ctrl_cnt_o / data_cnt_o behave as above.
- Undefined: counter registers are not built and both outputs are tied to 16'h0000. All other behaviour is identical.

Test Plan:
- Single request: ctrl_req_i in cycle 0 from IDLE -> ctrl_start_o in cycle 1, sel_data_o=0, busy_o=1. tx_done_i in cycle 20 -> busy_o falls after 12 GAP cycles (IFG_CYC=12).
- Simultaneous requests: ctrl_req_i and data_req_i in the same cycle from IDLE -> control granted first, data_pend_o=1. After done+IFG -> data_start_o, sel_data_o=1, data_pend_o=0.
- Starvation: data pending and control re-requested every frame -> 4 control grants, then the 5th grant is data (MAX_CTRL_RUN=4). run_cnt then restarts.
- Watchdog: TIMEOUT_CYC=100, grant with no tx_done_i -> timeout_o pulses 100 cycles after the start pulse. Any pending request is granted on the following edge.
- Merge and reset: three data_req_i during BUSY -> exactly one further data_start_o. rst_n low mid-BUSY -> all outputs 0 and pend bits cleared.
- Stats (TCP_TX_ARB_STATS_EN defined): preload ctrl_cnt to 0xFFFF via 65535 grants (or force) -> next control grant gives 0x0000. Without the macro, both counters read 0 throughout.
